// File: rtl/video_timing_pkg.sv
// Shared constants for the video timing generator: 720p60 defaults and position width.
package video_timing_pkg;

    localparam int unsigned POS_W = 12;

    localparam int unsigned HRES_720P = 1280;
    localparam int unsigned HFP_720P  = 110;
    localparam int unsigned HSW_720P  = 40;
    localparam int unsigned HBP_720P  = 220;
    localparam int unsigned VRES_720P = 720;
    localparam int unsigned VFP_720P  = 5;
    localparam int unsigned VSW_720P  = 5;
    localparam int unsigned VBP_720P  = 20;

    localparam int unsigned HTOTAL_720P = HRES_720P + HFP_720P + HSW_720P + HBP_720P;
    localparam int unsigned VTOTAL_720P = VRES_720P + VFP_720P + VSW_720P + VBP_720P;

    typedef logic [POS_W-1:0] pos_t;

endpackage

// File: rtl/wrap_counter.sv
// Enabled up-counter that wraps from max to 0; resets to max so the first enabled
// edge lands on 0.
module wrap_counter #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] One = 1;

    logic [WIDTH-1:0] value_q, value_d;

    // Terminal count, not gated by en; callers qualify it.
    assign wrap  = (value_q == max);
    assign value = value_q;

    always_comb begin
        value_d = value_q;
        if (en) begin
            value_d = wrap ? '0 : value_q + One;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= max;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: h/v position counters with registered, zero-skew
// de/hsync/vsync/fsync decode and a frame counter.
module video_timing
    import video_timing_pkg::*;
#(
    parameter int unsigned HRES     = HRES_720P,
    parameter int unsigned HFP      = HFP_720P,
    parameter int unsigned HSW      = HSW_720P,
    parameter int unsigned HBP      = HBP_720P,
    parameter int unsigned VRES     = VRES_720P,
    parameter int unsigned VFP      = VFP_720P,
    parameter int unsigned VSW      = VSW_720P,
    parameter int unsigned VBP      = VBP_720P,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic                    pixel_clk,
    input  logic                    rst_n,
    input  logic                    en,
    output logic signed [POS_W-1:0] hpos,
    output logic signed [POS_W-1:0] vpos,
    output logic                    de,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    fsync,
    output logic [15:0]             frame_cnt
);

    localparam int unsigned HTOTAL = HRES + HFP + HSW + HBP;
    localparam int unsigned VTOTAL = VRES + VFP + VSW + VBP;

    localparam pos_t One      = pos_t'(1);
    localparam pos_t HMax     = pos_t'(HTOTAL - 1);
    localparam pos_t VMax     = pos_t'(VTOTAL - 1);
    localparam pos_t HActEnd  = pos_t'(HRES);
    localparam pos_t VActEnd  = pos_t'(VRES);
    localparam pos_t HSyncBeg = pos_t'(HRES + HFP);
    localparam pos_t HSyncEnd = pos_t'(HRES + HFP + HSW);
    localparam pos_t VSyncBeg = pos_t'(VRES + VFP);
    localparam pos_t VSyncEnd = pos_t'(VRES + VFP + VSW);

    pos_t h_val, v_val, h_nxt, v_nxt;
    logic h_wrap, v_wrap, v_en;
    logic de_q, hsync_q, vsync_q, fsync_q;
    logic [15:0] frame_cnt_q;

    assign v_en = h_wrap & en;

    wrap_counter #(
        .WIDTH(POS_W)
    ) u_hcnt (
        .clk  (pixel_clk),
        .rst_n(rst_n),
        .en   (en),
        .max  (HMax),
        .value(h_val),
        .wrap (h_wrap)
    );

    wrap_counter #(
        .WIDTH(POS_W)
    ) u_vcnt (
        .clk  (pixel_clk),
        .rst_n(rst_n),
        .en   (v_en),
        .max  (VMax),
        .value(v_val),
        .wrap (v_wrap)
    );

    // Decode looks at the position the counters are about to take, so the
    // registered flags line up with the registered counts.
    always_comb begin
        h_nxt = h_val;
        v_nxt = v_val;
        if (en) begin
            h_nxt = h_wrap ? '0 : h_val + One;
        end
        if (v_en) begin
            v_nxt = v_wrap ? '0 : v_val + One;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q        <= 1'b0;
            hsync_q     <= ~SYNC_POL;
            vsync_q     <= ~SYNC_POL;
            fsync_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            de_q    <= (h_nxt < HActEnd) && (v_nxt < VActEnd);
            hsync_q <= (h_nxt >= HSyncBeg && h_nxt < HSyncEnd) ? SYNC_POL : ~SYNC_POL;
            vsync_q <= (v_nxt >= VSyncBeg && v_nxt < VSyncEnd) ? SYNC_POL : ~SYNC_POL;
            // Only a real advance into (0,VRES) pulses; holding there with en=0 does not.
            fsync_q     <= en && (h_nxt == '0) && (v_nxt == VActEnd);
            frame_cnt_q <= frame_cnt_q + {15'b0, fsync_q};
        end
    end

    assign hpos      = h_val;
    assign vpos      = v_val;
    assign de        = de_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign fsync     = fsync_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_video_timing.sv
// Randomized self-checking bench for video_timing using a small raster and a
// position-level reference model.
module tb_video_timing;

    localparam int HRES = 16;
    localparam int HFP  = 3;
    localparam int HSW  = 4;
    localparam int HBP  = 5;
    localparam int VRES = 10;
    localparam int VFP  = 2;
    localparam int VSW  = 3;
    localparam int VBP  = 4;
    localparam int HT   = HRES + HFP + HSW + HBP;
    localparam int VT   = VRES + VFP + VSW + VBP;
    localparam bit POL  = 1'b0;

    logic               pixel_clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic signed [11:0] hpos, vpos;
    logic               de, hsync, vsync, fsync;
    logic [15:0]        frame_cnt;

    video_timing #(
        .HRES(HRES), .HFP(HFP), .HSW(HSW), .HBP(HBP),
        .VRES(VRES), .VFP(VFP), .VSW(VSW), .VBP(VBP),
        .SYNC_POL(POL)
    ) dut (
        .pixel_clk(pixel_clk),
        .rst_n    (rst_n),
        .en       (en),
        .hpos     (hpos),
        .vpos     (vpos),
        .de       (de),
        .hsync    (hsync),
        .vsync    (vsync),
        .fsync    (fsync),
        .frame_cnt(frame_cnt)
    );

    always #5 pixel_clk = ~pixel_clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          mx, my, cyc, hs_line0;
    logic        mfs;
    logic [15:0] mcnt;
    int          fs_cyc[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all();
        int exp_hs, exp_vs;
        exp_hs = (mx >= HRES + HFP && mx < HRES + HFP + HSW) ? int'(POL) : int'(!POL);
        exp_vs = (my >= VRES + VFP && my < VRES + VFP + VSW) ? int'(POL) : int'(!POL);
        check_eq("hpos", hpos, mx);
        check_eq("vpos", vpos, my);
        check_eq("de", de, (mx < HRES && my < VRES) ? 1 : 0);
        check_eq("hsync", hsync, exp_hs);
        check_eq("vsync", vsync, exp_vs);
        check_eq("fsync", fsync, int'(mfs));
        check_eq("frame_cnt", frame_cnt, int'(mcnt));
    endtask

    task automatic model_reset();
        mx   = HT - 1;
        my   = VT - 1;
        mfs  = 1'b0;
        mcnt = 16'h0;
    endtask

    // Called at a negedge; applies en for the next rising edge, then checks.
    task automatic step(input logic en_v);
        en = en_v;
        @(posedge pixel_clk);
        if (mfs) mcnt = mcnt + 16'h1;
        if (en_v) begin
            mx = mx + 1;
            if (mx == HT) begin
                mx = 0;
                my = my + 1;
                if (my == VT) my = 0;
            end
        end
        mfs = en_v && mx == 0 && my == VRES;
        cyc++;
        @(negedge pixel_clk);
        check_all();
        if (fsync) fs_cyc.push_back(cyc);
    endtask

    task automatic seek(input int tx, input int ty);
        for (int i = 0; i < HT * VT + 2 && !(mx == tx && my == ty); i++) step(1'b1);
        check_eq("seek", (mx == tx && my == ty) ? 1 : 0, 1);
    endtask

    initial begin
        cyc      = 0;
        hs_line0 = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        model_reset();
        repeat (3) @(negedge pixel_clk);
        check_all();
        check_eq("rst_hpos", hpos, HT - 1);

        // Continuous run over two frames.
        rst_n = 1'b1;
        step(1'b1);
        check_eq("first_hpos", hpos, 0);
        check_eq("first_de", de, 1);
        if (hsync == POL) hs_line0++;
        for (int i = 0; i < 2 * HT * VT + 2; i++) begin
            step(1'b1);
            if (cyc <= HT && hsync == POL) hs_line0++;
        end
        check_eq("hsync_width", hs_line0, HSW);
        check_eq("fsync_count", fs_cyc.size(), 2);
        if (fs_cyc.size() >= 2) check_eq("fsync_period", fs_cyc[1] - fs_cyc[0], HT * VT);
        check_eq("frame_cnt2", frame_cnt, 2);

        // Random en.
        for (int i = 0; i < 2 * HT * VT; i++) step(1'(($urandom() >> 7) & 1));

        // Asynchronous mid-frame reset.
        seek(HRES / 2, VRES / 2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge pixel_clk);
        rst_n = 1'b1;
        step(1'b1);
        check_eq("restart_h", hpos, 0);
        check_eq("restart_v", vpos, 0);
        check_eq("restart_cnt", frame_cnt, 0);
        repeat (HT + 5) step(1'b1);

        // Preload the frame counter and let one fsync roll it over.
        seek(3, 2);
        force dut.frame_cnt_q = 16'hFFFF;
        #1 release dut.frame_cnt_q;
        mcnt = 16'hFFFF;
        check_eq("preload", frame_cnt, 16'hFFFF);
        fs_cyc.delete();
        for (int i = 0; i < HT * VT && fs_cyc.size() == 0; i++) step(1'b1);
        check_eq("wrap_fsync_seen", fs_cyc.size(), 1);
        step(1'b1);
        step(1'b1);
        check_eq("cnt_wrap", frame_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
